delta_demodulator: RTL

- Receive-side counterpart of the delta-modulation encoder. Rebuilds a W-bit amplitude estimate from the encoder's on/off spike stream.
- Each accepted spike moves the estimate up or down by the shared threshold step, saturating at the range limits.
- An optional idle leak pulls the estimate toward mid-scale.
- Each reconstructed sample is presented on a valid/ready output port, so the block can drive a DAC or PWM stage, or loop back into the encoder for self-check.

---
 rtl/delta_pkg.sv | 24 ++
 rtl/delta_demodulator_if.sv | 27 ++
 rtl/delta_leak_timer.sv | 46 ++++
 rtl/delta_demodulator.sv | 111 +++++++++++
 4 files changed

// File: rtl/delta_pkg.sv
// rtl/delta_pkg.sv - shared delta-modulation constants and range helpers
// Contents:
//   W_DEFAULT          default data/threshold width
//   SPIKE_*            two-bit spike encoding shared by encoder and demodulator
//   mid_of / max_of    mid-scale and full-scale values for a given width
package delta_pkg;

  localparam int unsigned W_DEFAULT = 4;

  // bit0 = on (up) spike, bit1 = off (down) spike
  localparam logic [1:0] SPIKE_NONE = 2'b00;
  localparam logic [1:0] SPIKE_ON   = 2'b01;
  localparam logic [1:0] SPIKE_OFF  = 2'b10;
  localparam logic [1:0] SPIKE_BAD  = 2'b11;

  function automatic int unsigned mid_of(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/delta_demodulator_if.sv
// rtl/delta_demodulator_if.sv - spike input and sample output handshakes
// Signals:
//   spike_valid/spike/spike_ready   incoming spike events (master -> slave)
//   out_valid/out_data/out_ready    reconstructed samples (slave -> master)
// Modports: master = spike source / sample consumer, slave = demodulator
interface delta_demodulator_if
  import delta_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
);
  logic         spike_valid;
  logic [1:0]   spike;
  logic         spike_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (
    output spike_valid, spike, out_ready,
    input  spike_ready, out_valid, out_data
  );

  modport slave (
    input  spike_valid, spike, out_ready,
    output spike_ready, out_valid, out_data
  );
endinterface

// File: rtl/delta_leak_timer.sv
// rtl/delta_leak_timer.sv - idle counter that paces the leak toward mid-scale
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear_i    restart the idle count from zero
//   hold_i     freeze the count (leak deferred by a full output slot)
//   tick_o     count has reached LEAK_CYCLES-1; always 0 when LEAK_CYCLES == 0
module delta_leak_timer #(
  parameter int unsigned LEAK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic hold_i,
  output logic tick_o
);

  generate
    if (LEAK_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear_i, hold_i};
      assign tick_o = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = (LEAK_CYCLES > 1) ? $clog2(LEAK_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(LEAK_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Saturates at LAST so a deferred leak keeps its tick asserted.
      always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
          cnt_d = '0;
        else if (!hold_i && cnt_q != LAST)
          cnt_d = cnt_q + CW'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign tick_o = (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/delta_demodulator.sv
// rtl/delta_demodulator.sv - rebuilds an amplitude estimate from a delta spike stream
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   threshold_i     step applied per on/off spike
//   load_recon_i    force the estimate to force_value_i (wins over spikes and leak)
//   force_value_i   value loaded by load_recon_i
//   recon_o         current registered estimate
//   err_both_o      sticky: an on+off spike (2'b11) was accepted
//   bus (slave)     spike input handshake and sample output handshake
module delta_demodulator
  import delta_pkg::*;
#(
  parameter int unsigned W           = W_DEFAULT,
  parameter int unsigned LEAK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         threshold_i,
  input  logic                 load_recon_i,
  input  logic [W-1:0]         force_value_i,
  output logic [W-1:0]         recon_o,
  output logic                 err_both_o,
  delta_demodulator_if.slave   bus
);

  localparam logic [W-1:0] MID = W'(mid_of(W));
  localparam logic [W-1:0] MAX = W'(max_of(W));

  logic [W-1:0] recon_q, recon_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         err_q, err_d;

  logic         slot_free, accept, legal, emit;
  logic         timer_tick, leak_tick, leak_go, leak_hold;
  logic [W:0]   up_sum;
  logic [W-1:0] up_val, down_val, leak_val;

  assign slot_free       = !out_valid_q || bus.out_ready;
  assign bus.spike_ready = !load_recon_i && slot_free;
  assign accept          = bus.spike_valid && bus.spike_ready;
  assign legal           = accept && (bus.spike == SPIKE_ON || bus.spike == SPIKE_OFF);

  // Extra carry bit detects overflow past MAX.
  assign up_sum   = {1'b0, recon_q} + {1'b0, threshold_i};
  assign up_val   = up_sum[W] ? MAX : up_sum[W-1:0];
  assign down_val = (recon_q >= threshold_i) ? recon_q - threshold_i : '0;
  assign leak_val = (recon_q > MID) ? recon_q - W'(1) : recon_q + W'(1);

  // Leak only fires on otherwise idle cycles; at MID it just restarts the count.
  assign leak_tick = timer_tick && !load_recon_i && !legal;
  assign leak_go   = leak_tick && (recon_q != MID) && slot_free;
  assign leak_hold = leak_tick && (recon_q != MID) && !slot_free;

  delta_leak_timer #(.LEAK_CYCLES(LEAK_CYCLES)) u_leak_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (load_recon_i || legal || (leak_tick && !leak_hold)),
    .hold_i  (leak_hold),
    .tick_o  (timer_tick)
  );

  always_comb begin
    recon_d = recon_q;
    emit    = 1'b0;
    err_d   = err_q;
    if (load_recon_i) begin
      recon_d = force_value_i;
    end else if (legal) begin
      recon_d = (bus.spike == SPIKE_ON) ? up_val : down_val;
      emit    = 1'b1;
    end else if (leak_go) begin
      recon_d = leak_val;
      emit    = 1'b1;
    end
    if (accept && bus.spike == SPIKE_BAD)
      err_d = 1'b1;
  end

  // Emits only happen when the slot is free, so a pending sample is never overwritten.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = recon_d;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      recon_q     <= MID;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      recon_q     <= recon_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign recon_o       = recon_q;
  assign err_both_o    = err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
